fifo_drain: RTL
===============

// Module: fifo_drain
// PURPOSE
//  Downstream consumer stage for fifo_flops: pops words while pndng=1 and forwards them on a valid/ready stream.
//  A 2-entry output buffer lets pops run back-to-back while the sink accepts, and absorbs one cycle of sink stall.
//  Sits between fifo_flops (Dout/pndng/pop) and any stream sink in the datapath.
// PARAMETERS
//  BITS   16  data width; must match the upstream fifo_flops BITS
//  CNT_W  16  width of the statistics counters (only when FIFO_DRAIN_STATS_EN is defined)
// PORTS
//  clk         in   1       single clock; all state changes on posedge
//  rst         in   1       asynchronous, active-low reset (0 = reset asserted)
//  en          in   1       1 = pops allowed; 0 = no new pops, buffered words still drain
//  fifo_dout   in   BITS    head word of fifo_flops; valid while fifo_pndng=1
//  fifo_pndng  in   1       fifo_flops not empty
//  fifo_pop    out  1       pop strobe to fifo_flops; combinational
//  dout        out  BITS    stream data = buffer head
//  dout_valid  out  1       buffer holds >=1 word
//  dout_ready  in   1       sink accepts dout this cycle
//  idle        out  1       buffer empty and fifo_pndng=0
//  words_out   out  CNT_W   (STATS only) words accepted by the sink
//  stall_cyc   out  CNT_W   (STATS only) cycles with dout_valid=1 and dout_ready=0
// BEHAVIOUR
//  - Upstream contract: fifo_dout is the head while fifo_pndng=1. fifo_pop=1 consumes the head at that posedge.
//    The next head and pndng are valid the following cycle.
//  - fifo_pop = en & fifo_pndng & (occ<2 | (occ==2 & dout_ready)); word captured at the same posedge.
//  - Buffer FSM on occ: EMPTY(0), ONE(1), TWO(2). With acc = dout_valid & dout_ready:
//      EMPTY: pop -> ONE, else EMPTY
//      ONE:   pop&!acc -> TWO; pop&acc or !pop&!acc -> ONE; !pop&acc -> EMPTY
//      TWO:   acc&pop -> TWO; acc&!pop -> ONE; !acc -> TWO (pop forced 0)
//  - Order preserved: dout always the oldest word. Simultaneous pop+accept in ONE: head replaced by the popped word.
//  - Latency: a word popped at edge N is on dout with dout_valid=1 from edge N (1 clk after pndng seen).
//  - Throughput: 1 word/clk while fifo_pndng=1, en=1, and dout_ready=1.
//  - dout stable while dout_valid=1 & dout_ready=0 (stream rule); dout_valid never drops without acc.
//  - en falls mid-stream: no further pops; buffer drains normally; idle not asserted while fifo_pndng=1.
//  - fifo_pndng=0: no pop ever issued (no underflow of fifo_flops), regardless of en/ready.
//  - Reset (rst=0, any time incl. mid-transfer): occ=EMPTY, dout_valid=0, dout=0, counters=0, fifo_pop=0 via gating.
//    Buffered words are discarded. First pop possible in the first cycle after rst rises.
//  - idle = (occ==EMPTY) & !fifo_pndng.
// CONFIGURATION
//  - FIFO_DRAIN_STATS_EN defined:
//    - words_out increments on each acc.
//    - stall_cyc increments each cycle with dout_valid & !dout_ready.
//    - Both saturate at all-ones (no wrap); cleared only by reset.
//  - Not defined: words_out/stall_cyc ports and counters absent; CNT_W unused.
// STRUCTURE
//  - Package fifo_drain_pkg: typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t; localparam MAX_OCC = 2.
//  - Sub-module drain_buf2: 2-entry register buffer (push/data_in, pop, head, occ).
//  - Top holds pop logic, idle, and the `ifdef FIFO_DRAIN_STATS_EN` counters.
// TESTING
//  - Bench drives a fifo_flops #(16,16) instance upstream; scoreboard compares dout sequence to push order.
//  1. Push 0..15 (fifo full), en=1, ready=1:
//     16 pops on consecutive cycles; dout 0..15 in order; idle=1 after last accept.
//  2. FIFO holds 3,4,5, ready=0:
//     exactly 2 pops; occ=TWO; fifo_pop=0 afterwards; dout=3 held stable.
//     ready=1 -> 3,4,5 delivered in 3 cycles.
//  3. FIFO empty, en=1, ready toggling for 20 cycles:
//     fifo_pop never 1; dout_valid=0; idle=1.
//  4. Stream 8 words, drop en after 4th pop:
//     only 4 pops; 4 words delivered; idle=0 (pndng=1); en=1 resumes with word 4.
//  5. rst=0 while occ=TWO: immediately dout_valid=0, fifo_pop=0.
//     After release, next dout = current fifo head.
//  6. STATS: 10 words, ready low 3 cycles while valid:
//     words_out=10, stall_cyc=3.
//     Force counters to 2^16-2, run 5 more -> saturate at 16'hFFFF.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types for the fifo_drain stream stage: buffer occupancy encoding and depth.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam int unsigned MAX_OCC = 2;

endpackage

// File: rtl/fifo_drain_if.sv
// Upstream fifo_flops pop port plus downstream valid/ready stream, bundled for fifo_drain.
interface fifo_drain_if #(
    parameter int unsigned BITS = 16
) ();

    logic [BITS-1:0] fifo_dout;
    logic            fifo_pndng;
    logic            fifo_pop;
    logic [BITS-1:0] dout;
    logic            dout_valid;
    logic            dout_ready;

    // master = the drain stage, slave = the surrounding FIFO and sink
    modport master (
        input  fifo_dout, fifo_pndng, dout_ready,
        output fifo_pop, dout, dout_valid
    );

    modport slave (
        output fifo_dout, fifo_pndng, dout_ready,
        input  fifo_pop, dout, dout_valid
    );

endinterface

// File: rtl/drain_buf2.sv
// Two-entry register buffer; head is always the oldest word, push and pop may coincide.
module drain_buf2
    import fifo_drain_pkg::*;
#(
    parameter int unsigned BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_push,
    input  logic [BITS-1:0] i_data,
    input  logic            i_pop,
    output logic [BITS-1:0] o_head,
    output occ_t            o_occ,
    output logic            o_valid
);

    occ_t            r_state;
    occ_t            w_next;
    logic [BITS-1:0] r_head;
    logic [BITS-1:0] r_tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            EMPTY: if (i_push) w_next = ONE;
            ONE: begin
                if (i_push && !i_pop)      w_next = TWO;
                else if (!i_push && i_pop) w_next = EMPTY;
            end
            TWO:   if (i_pop && !i_push) w_next = ONE;
            default: w_next = EMPTY;
        endcase
    end

    always_comb begin
        o_head  = r_head;
        o_occ   = r_state;
        o_valid = (r_state != EMPTY);
    end

    // Storage follows the occupancy: a pop in TWO promotes the tail to head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                EMPTY: if (i_push) r_head <= i_data;
                ONE: begin
                    if (i_push && i_pop)  r_head <= i_data;
                    else if (i_push)      r_tail <= i_data;
                end
                TWO: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// Pops fifo_flops while words are pending and forwards them on a valid/ready stream.
// Optional statistics counters are built when FIFO_DRAIN_STATS_EN is defined.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    fifo_drain_if.master       bus,
    output logic               idle
`ifdef FIFO_DRAIN_STATS_EN
   ,output logic [CNT_W-1:0]   words_out,
    output logic [CNT_W-1:0]   stall_cyc
`endif
);

    logic [BITS-1:0] w_head;
    occ_t            w_occ;
    logic            w_valid;
    logic            w_acc;
    logic            w_pop;

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("fifo_drain: CNT_W must be nonzero");
    end

    assign w_acc = w_valid & bus.dout_ready;
    // A full buffer only takes a new word when the head leaves in the same cycle
    assign w_pop = rst & en & bus.fifo_pndng &
                   ((w_occ != occ_t'(MAX_OCC)) | bus.dout_ready);

    drain_buf2 #(
        .BITS (BITS)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_pop),
        .i_data  (bus.fifo_dout),
        .i_pop   (w_acc),
        .o_head  (w_head),
        .o_occ   (w_occ),
        .o_valid (w_valid)
    );

    assign bus.fifo_pop   = w_pop;
    assign bus.dout       = w_head;
    assign bus.dout_valid = w_valid;
    assign idle           = (w_occ == EMPTY) & ~bus.fifo_pndng;

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_W-1:0] r_words_out;
    logic [CNT_W-1:0] r_stall_cyc;

    // Saturating counters, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_words_out <= '0;
            r_stall_cyc <= '0;
        end else begin
            if (w_acc && (r_words_out != '1))
                r_words_out <= r_words_out + CNT_W'(1);
            if (w_valid && !bus.dout_ready && (r_stall_cyc != '1))
                r_stall_cyc <= r_stall_cyc + CNT_W'(1);
        end
    end

    assign words_out = r_words_out;
    assign stall_cyc = r_stall_cyc;
`endif

endmodule
